// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 phase sequencer.
//   PH_*                 : phase codes driven onto NS towards key_gene
//   rc4_seq_state_t      : sequencer state encoding
//   KSA_TIMEOUT_DEFAULT  : default key-schedule watchdog length in cycles
//   phase_of()           : phase code that belongs to each sequencer state
package rc4_pkg;

  localparam logic [1:0] PH_INIT       = 2'b00;
  localparam logic [1:0] PH_KEY_GENE   = 2'b01;
  localparam logic [1:0] PH_EN_DE_CODE = 2'b10;

  localparam int KSA_TIMEOUT_DEFAULT = 512;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KSA   = 3'd1,
    S_COPY  = 3'd2,
    S_CRYPT = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } rc4_seq_state_t;

  // Idle, done and error all park key_gene in INIT so it clears j/count.
  function automatic logic [1:0] phase_of(input rc4_seq_state_t st);
    case (st)
      S_KSA, S_COPY:    phase_of = PH_KEY_GENE;
      S_CRYPT, S_FLUSH: phase_of = PH_EN_DE_CODE;
      default:          phase_of = PH_INIT;
    endcase
  endfunction

endpackage

// File: rtl/rc4_xor_stage.sv
// Output register of the crypt datapath: one dout byte plus its valid flag.
//   clk, rst   : clock, asynchronous active-high reset
//   load       : a byte is accepted this cycle (capture din ^ ks_byte)
//   din        : host byte
//   ks_byte    : current keystream byte
//   dout_ready : sink takes dout this cycle
//   dout       : registered din ^ ks_byte
//   dout_valid : dout holds an untaken byte
//   room       : register can take a new byte this cycle
module rc4_xor_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic [7:0] ks_byte,
  input  logic       dout_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       room
);

  logic [7:0] dout_r;
  logic       dout_valid_r;

  // A new byte overwrites the register even while the old one is being
  // taken, so a continuously ready sink sees one byte per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r       <= 8'h00;
      dout_valid_r <= 1'b0;
    end else if (load) begin
      dout_r       <= din ^ ks_byte;
      dout_valid_r <= 1'b1;
    end else if (dout_ready) begin
      dout_valid_r <= 1'b0;
    end else begin
      dout_valid_r <= dout_valid_r;
    end
  end

  assign room       = !dout_valid_r || dout_ready;
  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;

endmodule

// File: rtl/rc4_seq_ctrl.sv
// Phase sequencer for the RC4 core. Walks key_gene through key schedule,
// S-box copy and en/decode, streams the message through the XOR stage and
// reports completion or key-schedule timeout to the host.
//   clk, rst                : clock, asynchronous active-high reset
//   start, msg_len          : job request (taken only when idle) and length
//   busy, done, err_timeout : host status
//   NS                      : registered phase code to key_gene
//   data_rready             : key_gene key schedule finished
//   ks_valid, ks_byte       : keystream byte in; ks_next pulses once consumed
//   din, din_valid/ready    : host byte stream in
//   dout, dout_valid/ready  : XORed byte stream out
module rc4_seq_ctrl
  import rc4_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int KSA_TIMEOUT = KSA_TIMEOUT_DEFAULT,
  parameter int COPY_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic [1:0]       NS,
  input  logic             data_rready,
  input  logic             ks_valid,
  input  logic [7:0]       ks_byte,
  output logic             ks_next,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready
);

  localparam int TMR_W = $clog2(KSA_TIMEOUT) + 1;
  localparam int CPY_W = (COPY_CYCLES > 1) ? $clog2(COPY_CYCLES) : 1;

  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(KSA_TIMEOUT - 1);
  localparam logic [CPY_W-1:0] CPY_ZERO = {CPY_W{1'b0}};
  localparam logic [CPY_W-1:0] CPY_ONE  = {{(CPY_W-1){1'b0}}, 1'b1};
  localparam logic [CPY_W-1:0] CPY_LOAD = CPY_W'(COPY_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  rc4_seq_state_t state_r, state_s;

  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] byte_cnt_r;
  logic [LEN_W-1:0] byte_inc_s;
  logic [TMR_W-1:0] timer_r;
  logic [CPY_W-1:0] copy_r;
  logic [1:0]       ns_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic             ks_next_r;

  logic start_ok_s;
  logic din_ready_s;
  logic accept_s;
  logic last_byte_s;
  logic room_s;

  // Handshake terms: accept needs keystream, output room and bytes left.
  always_comb begin
    start_ok_s  = (state_r == S_IDLE) && start;
    din_ready_s = (state_r == S_CRYPT) && ks_valid && room_s &&
                  (byte_cnt_r != len_r);
    accept_s    = din_ready_s && din_valid;
    byte_inc_s  = byte_cnt_r + LEN_ONE;
    last_byte_s = accept_s && (byte_inc_s == len_r);
  end

  // Next-state logic. In S_KSA a completion seen on the timeout cycle wins.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_KSA;
        else       state_s = S_IDLE;
      end
      S_KSA: begin
        if (data_rready)             state_s = S_COPY;
        else if (timer_r == TMR_LAST) state_s = S_ERR;
        else                         state_s = S_KSA;
      end
      S_COPY: begin
        if (copy_r != CPY_ZERO)   state_s = S_COPY;
        else if (len_r != LEN_ZERO) state_s = S_CRYPT;
        else                      state_s = S_DONE;
      end
      S_CRYPT: begin
        if (last_byte_s) state_s = S_FLUSH;
        else             state_s = S_CRYPT;
      end
      S_FLUSH: begin
        if (!dout_valid || dout_ready) state_s = S_DONE;
        else                           state_s = S_FLUSH;
      end
      S_DONE:  state_s = S_IDLE;
      S_ERR:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // State plus the status outputs, all derived from the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= S_IDLE;
      ns_r      <= PH_INIT;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ks_next_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ns_r      <= phase_of(state_s);
      busy_r    <= (state_s == S_KSA) || (state_s == S_COPY) ||
                   (state_s == S_CRYPT) || (state_s == S_FLUSH);
      done_r    <= (state_s == S_DONE);
      ks_next_r <= accept_s;
    end
  end

  // Sticky timeout flag, cleared only by the next accepted job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (start_ok_s) begin
      err_r <= 1'b0;
    end else if (state_s == S_ERR) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Job length latch and byte counter; the counter stops at len_r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_r      <= LEN_ZERO;
      byte_cnt_r <= LEN_ZERO;
    end else if (start_ok_s) begin
      len_r      <= msg_len;
      byte_cnt_r <= LEN_ZERO;
    end else if (accept_s) begin
      len_r      <= len_r;
      byte_cnt_r <= byte_inc_s;
    end else begin
      len_r      <= len_r;
      byte_cnt_r <= byte_cnt_r;
    end
  end

  // Key-schedule watchdog; saturates so it can never wrap back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= TMR_ZERO;
    end else if (start_ok_s) begin
      timer_r <= TMR_ZERO;
    end else if ((state_r == S_KSA) && (timer_r != TMR_MAX)) begin
      timer_r <= timer_r + TMR_ONE;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Copy-phase down-counter, loaded as key_gene reports completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      copy_r <= CPY_ZERO;
    end else if ((state_r == S_KSA) && data_rready) begin
      copy_r <= CPY_LOAD;
    end else if ((state_r == S_COPY) && (copy_r != CPY_ZERO)) begin
      copy_r <= copy_r - CPY_ONE;
    end else begin
      copy_r <= copy_r;
    end
  end

  rc4_xor_stage u_xor (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_s),
    .din        (din),
    .ks_byte    (ks_byte),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .room       (room_s)
  );

  assign din_ready   = din_ready_s;
  assign NS          = ns_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_timeout = err_r;
  assign ks_next     = ks_next_r;

endmodule

// File: tb/tb_rc4_seq_ctrl.sv
module tb_rc4_seq_ctrl;
  localparam int COPY = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] msg_len = 16'd0;
  logic        busy, done, err_timeout, ks_next, din_ready, dout_valid;
  logic [1:0]  NS;
  logic        data_rready = 1'b0;
  logic        ks_valid = 1'b1;
  logic [7:0]  ks_byte = 8'h00;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic [7:0]  dout;
  logic        dout_ready = 1'b1;

  int checks = 0;
  int failures = 0;

  // bench state
  logic [7:0] src_q[$];
  logic [7:0] sb_q[$];
  int  rdy_delay = 20;
  bit  ks_toggle = 1'b0;
  int  acc_cnt = 0;
  int  ks_next_cnt, done_cnt, rdy_cnt, ns01_cnt, viol, pops, trace_len;
  logic [15:0] trace_v;
  logic [1:0]  last_ns = 2'b00;

  rc4_seq_ctrl #(.LEN_W(16), .KSA_TIMEOUT(512), .COPY_CYCLES(COPY)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len), .busy(busy),
    .done(done), .err_timeout(err_timeout), .NS(NS), .data_rready(data_rready),
    .ks_valid(ks_valid), .ks_byte(ks_byte), .ks_next(ks_next), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 clk = ~clk;

  // key_gene model: raises data_rready after rdy_delay cycles of NS==01
  initial begin
    int ns_cnt;
    ns_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (NS === 2'b01) ns_cnt++; else ns_cnt = 0;
      data_rready = (rdy_delay != 0) && (ns_cnt > rdy_delay);
    end
  end

  // host source: presents src_q bytes, pushes expected dout on each accept
  initial begin
    bit acc;
    forever begin
      @(negedge clk);
      acc = (din_valid === 1'b1) && (din_ready === 1'b1);
      if (acc) begin
        sb_q.push_back(din ^ ks_byte);
        acc_cnt++;
      end
      @(posedge clk); #1;
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin din_valid = 1'b1; din = src_q[0]; end
      else din_valid = 1'b0;
      if (ks_toggle) ks_valid = ~ks_valid;
    end
  end

  // monitor: statistics, protocol violations and scoreboard compare
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (ks_next === 1'b1) ks_next_cnt++;
    if (done === 1'b1) done_cnt++;
    if (din_ready === 1'b1) rdy_cnt++;
    if (NS === 2'b01) ns01_cnt++;
    if (NS !== last_ns) begin
      trace_v = {trace_v[13:0], NS};
      trace_len++;
      last_ns = NS;
    end
    if (din_ready === 1'b1 && ks_valid !== 1'b1) viol++;
    if (din_ready === 1'b1 && dout_valid === 1'b1 && dout_ready !== 1'b1) viol++;
    if (done === 1'b1 && busy !== 1'b0) viol++;
    if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: dout=%02h with no expected byte", dout);
      end else begin
        exp_b = sb_q.pop_front();
        pops++;
        if (dout !== exp_b) begin
          failures++;
          $display("FAIL sb_dout: got %02h expected %02h", dout, exp_b);
        end
      end
    end
  end

  task automatic clear_stats();
    ks_next_cnt = 0; done_cnt = 0; rdy_cnt = 0; ns01_cnt = 0;
    viol = 0; pops = 0; trace_len = 0; trace_v = 16'h0000; acc_cnt = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_job(input logic [15:0] len);
    @(posedge clk); #1;
    start = 1'b1; msg_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin timed_out = 1'b0; break; end
    end
  endtask

  task automatic load_src(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) src_q.push_back(base + 8'(i));
  endtask

  task automatic test_reset();
    cycles(2);
    checks++;
    if ({NS, busy, done, err_timeout, ks_next, dout_valid, din_ready} !== 8'h00) begin
      failures++;
      $display("FAIL reset_ctrl: NS,busy,done,err,ks_next,dv,drdy=%b expected 00000000",
               {NS, busy, done, err_timeout, ks_next, dout_valid, din_ready});
    end
    checks++;
    if (dout !== 8'h00) begin
      failures++; $display("FAIL reset_dout: got %02h expected 00", dout);
    end
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_basic();
    bit to;
    clear_stats();
    rdy_delay = 257; ks_byte = 8'hA5; dout_ready = 1'b1;
    load_src(4, 8'h00);
    start_job(16'd4);
    checks++;
    if (busy !== 1'b1 || NS !== 2'b01) begin
      failures++; $display("FAIL basic_start: busy=%b NS=%b expected 1 01", busy, NS);
    end
    wait_done(600, to);
    checks++;
    if (to) begin failures++; $display("FAIL basic_done_timeout: no done within 600 cycles"); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: busy=%b expected 0", busy); end
    cycles(3);
    checks++;
    if (trace_len != 3 || trace_v[5:0] !== 6'b01_10_00) begin
      failures++; $display("FAIL basic_ns_trace: len=%0d seq=%b expected 3 011000", trace_len, trace_v[5:0]);
    end
    checks++;
    if (ns01_cnt != 257 + 1 + COPY) begin
      failures++; $display("FAIL basic_ns01_cycles: got %0d expected %0d", ns01_cnt, 257 + 1 + COPY);
    end
    checks++;
    if (ks_next_cnt != 4 || pops != 4 || sb_q.size() != 0) begin
      failures++; $display("FAIL basic_bytes: ks_next=%0d out=%0d left=%0d expected 4 4 0", ks_next_cnt, pops, sb_q.size());
    end
    checks++;
    if (done_cnt != 1 || viol != 0) begin
      failures++; $display("FAIL basic_done_pulse: done_cycles=%0d viol=%0d expected 1 0", done_cnt, viol);
    end
  endtask

  task automatic test_zero_len();
    bit to;
    clear_stats();
    rdy_delay = 20;
    load_src(1, 8'h55);
    start_job(16'd0);
    wait_done(100, to);
    checks++;
    if (to) begin failures++; $display("FAIL zero_done_timeout: no done within 100 cycles"); end
    cycles(3);
    checks++;
    if (trace_len != 2 || trace_v[3:0] !== 4'b01_00) begin
      failures++; $display("FAIL zero_ns_trace: len=%0d seq=%b expected 2 0100", trace_len, trace_v[3:0]);
    end
    checks++;
    if (rdy_cnt != 0 || ks_next_cnt != 0 || done_cnt != 1) begin
      failures++; $display("FAIL zero_activity: din_ready=%0d ks_next=%0d done=%0d expected 0 0 1", rdy_cnt, ks_next_cnt, done_cnt);
    end
    src_q.delete();
    cycles(2);
  endtask

  task automatic test_timeout();
    bit to, seen;
    clear_stats();
    rdy_delay = 0;
    load_src(2, 8'h10);
    ks_byte = 8'h0F;
    start_job(16'd2);
    seen = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (err_timeout === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL tmo_no_err: err_timeout never set within 700 cycles"); end
    checks++;
    if (NS !== 2'b00 || busy !== 1'b0 || done_cnt != 0) begin
      failures++; $display("FAIL tmo_state: NS=%b busy=%b done=%0d expected 00 0 0", NS, busy, done_cnt);
    end
    checks++;
    if (ns01_cnt != 512) begin failures++; $display("FAIL tmo_ksa_cycles: got %0d expected 512", ns01_cnt); end
    cycles(3);
    checks++;
    if (err_timeout !== 1'b1) begin failures++; $display("FAIL tmo_sticky: err_timeout=%b expected 1", err_timeout); end
    clear_stats();
    rdy_delay = 5;
    start_job(16'd2);
    checks++;
    if (err_timeout !== 1'b0) begin failures++; $display("FAIL tmo_clear: err_timeout=%b expected 0", err_timeout); end
    wait_done(100, to);
    cycles(2);
    checks++;
    if (to || ks_next_cnt != 2 || pops != 2) begin
      failures++; $display("FAIL tmo_rerun: timeout=%0d ks_next=%0d out=%0d expected 0 2 2", to, ks_next_cnt, pops);
    end
  endtask

  task automatic test_backpressure();
    bit to, seen;
    logic [7:0] held;
    clear_stats();
    rdy_delay = 5; ks_byte = 8'h3C; dout_ready = 1'b0;
    load_src(3, 8'hC0);
    start_job(16'd3);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dout_valid === 1'b1) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bp_no_output: dout_valid never set"); end
    held = dout;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (din_ready !== 1'b0 || dout_valid !== 1'b1 || dout !== held) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d din_ready=%b dv=%b dout=%02h expected 0 1 %02h", i, din_ready, dout_valid, dout, held);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    wait_done(100, to);
    cycles(2);
    checks++;
    if (to || ks_next_cnt != 3 || pops != 3 || sb_q.size() != 0 || viol != 0) begin
      failures++; $display("FAIL bp_finish: timeout=%0d ks_next=%0d out=%0d left=%0d viol=%0d expected 0 3 3 0 0", to, ks_next_cnt, pops, sb_q.size(), viol);
    end
  endtask

  task automatic test_ks_toggle();
    bit to;
    clear_stats();
    rdy_delay = 5; ks_byte = 8'h5A;
    load_src(5, 8'h20);
    ks_toggle = 1'b1;
    start_job(16'd5);
    wait_done(200, to);
    cycles(2);
    ks_toggle = 1'b0; ks_valid = 1'b1;
    checks++;
    if (to || viol != 0) begin failures++; $display("FAIL kst_stall: timeout=%0d viol=%0d expected 0 0", to, viol); end
    checks++;
    if (ks_next_cnt != 5 || rdy_cnt != 5 || pops != 5) begin
      failures++; $display("FAIL kst_count: ks_next=%0d din_ready=%0d out=%0d expected 5 5 5", ks_next_cnt, rdy_cnt, pops);
    end
  endtask

  task automatic test_reset_midjob();
    bit to, got2;
    clear_stats();
    rdy_delay = 10; ks_byte = 8'h77;
    load_src(8, 8'h40);
    start_job(16'd8);
    cycles(2);
    start_job(16'd1);   // arrives in S_KSA, must be ignored
    got2 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (acc_cnt >= 2) begin got2 = 1'b1; break; end
    end
    checks++;
    if (!got2) begin failures++; $display("FAIL rstm_progress: accepted=%0d expected 2", acc_cnt); end
    rst = 1'b1;
    #1;
    checks++;
    if ({NS, busy, done, err_timeout, ks_next, dout_valid, din_ready} !== 8'h00 || dout !== 8'h00) begin
      failures++;
      $display("FAIL rstm_async: ctrl=%b dout=%02h expected 00000000 00",
               {NS, busy, done, err_timeout, ks_next, dout_valid, din_ready}, dout);
    end
    src_q.delete();
    sb_q.delete();
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    cycles(2);
    clear_stats();
    load_src(8, 8'h80);
    start_job(16'd8);
    wait_done(200, to);
    cycles(3);
    checks++;
    if (to || ks_next_cnt != 8 || pops != 8 || sb_q.size() != 0) begin
      failures++; $display("FAIL rstm_rerun: timeout=%0d ks_next=%0d out=%0d left=%0d expected 0 8 8 0", to, ks_next_cnt, pops, sb_q.size());
    end
    checks++;
    if (trace_len != 3 || trace_v[5:0] !== 6'b01_10_00) begin
      failures++; $display("FAIL rstm_ns_trace: len=%0d seq=%b expected 3 011000", trace_len, trace_v[5:0]);
    end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_basic();
    test_zero_len();
    test_timeout();
    test_backpressure();
    test_ks_toggle();
    test_reset_midjob();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // absolute guard against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
